// File: rtl/stage_sequencer_pkg.sv
// Shared definitions for the MUSA stage sequencer: state encodings,
// stage width and the default performance-counter width.
package musa_seq_pkg;

  localparam int STAGE_W   = 3;
  localparam int CNT_W_DEF = 32;

  typedef enum logic [STAGE_W-1:0] {
    S_FETCH     = 3'd0,
    S_DECODE    = 3'd1,
    S_EXECUTE   = 3'd2,
    S_MEMORY    = 3'd3,
    S_WRITEBACK = 3'd4,
    S_HALTED    = 3'd5
  } stage_e;

endpackage

// File: rtl/stage_sequencer_if.sv
// Memory request/ready handshake between the stage sequencer (master)
// and the instruction/data memory (slave).
interface stage_sequencer_if;

  logic mem_req;
  logic mem_fetch;
  logic mem_we;
  logic mem_ready;

  modport master (output mem_req, output mem_fetch, output mem_we, input mem_ready);
  modport slave  (input mem_req, input mem_fetch, input mem_we, output mem_ready);

endinterface

// File: rtl/stage_sequencer_perf_cnt.sv
// Cycle and retired-instruction counters for the stage sequencer; both wrap
// modulo 2^CNT_W and are frozen while the core sits in HALTED.
module seq_perf_cnt
  import musa_seq_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic [STAGE_W-1:0] i_stage,
  input  logic               i_halted,
  input  logic               i_pc_write,
  output logic [CNT_W-1:0]   o_cycle_cnt,
  output logic [CNT_W-1:0]   o_instret_cnt
);

  logic             w_in_halt;
  logic [CNT_W-1:0] r_cycle_cnt;
  logic [CNT_W-1:0] r_instret_cnt;

  // The pc_write that leaves HALTED is a resume, not a retirement.
  assign w_in_halt = i_halted | (i_stage == S_HALTED);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cycle_cnt   <= '0;
      r_instret_cnt <= '0;
    end else begin
      if (!w_in_halt) begin
        r_cycle_cnt <= r_cycle_cnt + CNT_W'(1);
      end
      if (i_pc_write && !w_in_halt) begin
        r_instret_cnt <= r_instret_cnt + CNT_W'(1);
      end
    end
  end

  assign o_cycle_cnt   = r_cycle_cnt;
  assign o_instret_cnt = r_instret_cnt;

endmodule

// File: rtl/stage_sequencer.sv
// Multi-cycle FETCH/DECODE/EXECUTE/MEMORY/WRITEBACK sequencer for the MUSA core.
// Define SEQ_PERF_CNT_EN to add the cycle/instret performance counters.
module stage_sequencer
  import musa_seq_pkg::*;
`ifdef SEQ_PERF_CNT_EN
#(
  parameter int CNT_W = CNT_W_DEF
)
`endif
(
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic                 i_dec_halt,
  input  logic                 i_dec_mem,
  input  logic                 i_dec_store,
  input  logic                 i_dec_wb,
  input  logic                 i_resume,
  stage_sequencer_if.master    mem_bus,
  output logic                 o_ir_write,
  output logic                 o_pc_write,
  output logic                 o_reg_write,
  output logic [STAGE_W-1:0]   o_stage,
  output logic                 o_halted
`ifdef SEQ_PERF_CNT_EN
  ,
  output logic [CNT_W-1:0]     o_cycle_cnt,
  output logic [CNT_W-1:0]     o_instret_cnt
`endif
);

  stage_e r_state;
  stage_e w_next_state;
  logic   w_ready;
  logic   w_mem_req;
  logic   w_mem_fetch;
  logic   w_mem_we;
  logic   w_ir_write;
  logic   w_pc_write;
  logic   w_reg_write;
  logic   w_halted;

  assign w_ready = mem_bus.mem_ready;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= S_FETCH;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = S_FETCH;
    case (r_state)
      S_FETCH:     w_next_state = w_ready ? S_DECODE : S_FETCH;
      S_DECODE:    w_next_state = i_dec_halt ? S_HALTED : S_EXECUTE;
      S_EXECUTE: begin
        if (i_dec_mem) begin
          w_next_state = S_MEMORY;
        end else if (i_dec_wb) begin
          w_next_state = S_WRITEBACK;
        end else begin
          w_next_state = S_FETCH;
        end
      end
      S_MEMORY: begin
        if (!w_ready) begin
          w_next_state = S_MEMORY;
        end else if (i_dec_store) begin
          w_next_state = S_FETCH;
        end else begin
          w_next_state = S_WRITEBACK;
        end
      end
      S_WRITEBACK: w_next_state = S_FETCH;
      S_HALTED:    w_next_state = i_resume ? S_FETCH : S_HALTED;
      default:     w_next_state = S_FETCH;
    endcase
  end

  always_comb begin
    w_mem_req   = 1'b0;
    w_mem_fetch = 1'b0;
    w_mem_we    = 1'b0;
    w_ir_write  = 1'b0;
    w_pc_write  = 1'b0;
    w_reg_write = 1'b0;
    w_halted    = 1'b0;
    case (r_state)
      S_FETCH: begin
        w_mem_req   = 1'b1;
        w_mem_fetch = 1'b1;
        w_ir_write  = w_ready;
      end
      S_DECODE: begin
        w_mem_req = 1'b0;
      end
      S_EXECUTE: begin
        w_pc_write = ~i_dec_mem & ~i_dec_wb;
      end
      S_MEMORY: begin
        w_mem_req  = 1'b1;
        w_mem_we   = i_dec_store;
        w_pc_write = w_ready & i_dec_store;
      end
      S_WRITEBACK: begin
        w_reg_write = 1'b1;
        w_pc_write  = 1'b1;
      end
      S_HALTED: begin
        w_halted   = 1'b1;
        w_pc_write = i_resume;
      end
      default: begin
        w_halted = 1'b0;
      end
    endcase
  end

  // Gating with rst_n drops the request and strobes asynchronously on reset.
  assign mem_bus.mem_req   = w_mem_req & i_rst_n;
  assign mem_bus.mem_fetch = w_mem_fetch & i_rst_n;
  assign mem_bus.mem_we    = w_mem_we & i_rst_n;
  assign o_ir_write        = w_ir_write & i_rst_n;
  assign o_pc_write        = w_pc_write & i_rst_n;
  assign o_reg_write       = w_reg_write & i_rst_n;
  assign o_halted          = w_halted & i_rst_n;
  assign o_stage           = r_state;

`ifdef SEQ_PERF_CNT_EN
  seq_perf_cnt #(
    .CNT_W (CNT_W)
  ) u_perf_cnt (
    .i_clk         (i_clk),
    .i_rst_n       (i_rst_n),
    .i_stage       (o_stage),
    .i_halted      (o_halted),
    .i_pc_write    (o_pc_write),
    .o_cycle_cnt   (o_cycle_cnt),
    .o_instret_cnt (o_instret_cnt)
  );
`endif

endmodule
